// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional perf counters in ifetch_unit are enabled with IFETCH_PERF_CNT_EN.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
// Head is read straight from registered storage, so outputs carry no logic from pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  entry_vec [DEPTH];

    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        fetch_entry_t entry_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
                entry_reg <= push_data;
            end
        end

        assign entry_vec[gi] = entry_reg;
    end

    assign head = entry_vec[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, reads imem combinationally, buffers words for decode.
// Define IFETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counter ports.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] HALT_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        halted
);

    state_t       state_reg;
    state_t       state_next;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic         enq;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t push_data;

    assign imem_addr   = pc_reg;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign halted      = (state_reg == HALT) && (fifo_count == '0);

    assign pop       = instr_valid && instr_ready;
    assign enq       = !fifo_full || pop;
    assign push_data = '{instr: imem_data, pc: pc_reg};

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = 1'b0;
        case (state_reg)
            BOOT: state_next = FETCH;
            FETCH: begin
                if (enq) begin
                    if (imem_data != HALT_WORD) begin
                        push    = 1'b1;
                        pc_next = pc_reg + PC_STEP;
                    end else begin
                        state_next = HALT;
                    end
                end
            end
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
        // Redirect overrides everything, including the BOOT cycle.
        if (redirect_valid) begin
            push       = 1'b0;
            pc_next    = redirect_pc & WORD_ALIGN_MASK;
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    ifetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (push && (perf_fetched_reg != '1)) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if ((state_reg == FETCH) && !enq && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with a 10-word instruction memory model.
// Exercises the IFETCH_PERF_CNT_EN counters only when that macro is defined.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [10];

    ifetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
`endif
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_data = 32'h0;
        if (imem_addr[31:2] < 30'd10) imem_data = rom[imem_addr[5:2]];
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        instr_ready = 1'b0;
        reset_dut();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h want 00000000", instr_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h want 00000000", imem_addr); end
        $display("test_reset done: valid=%b addr=%h", instr_valid, imem_addr);
    endtask

    task automatic test_stream;
        instr_ready = 1'b1;
        reset_dut();
        step(1);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_boot_valid got %b want 0", instr_valid); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++; if (instr_valid !== 1'b1 || instr !== rom[i] || instr_pc !== 32'(i * 4) || halted !== 1'b0) begin
                errors++;
                $display("FAIL stream_word%0d got v=%b %h@%h h=%b want v=1 %h@%h h=0", i, instr_valid, instr, instr_pc, halted, rom[i], 32'(i * 4));
            end
            $display("stream %0d: instr=%h pc=%h", i, instr, instr_pc);
        end
        step(1);
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL stream_halt got h=%b v=%b want h=1 v=0", halted, instr_valid); end
        step(2);
        checks++; if (imem_addr !== 32'h28 || halted !== 1'b1) begin errors++; $display("FAIL stream_halt_hold got addr=%h h=%b want 00000028 h=1", imem_addr, halted); end
    endtask

    task automatic test_backpressure;
        instr_ready = 1'b0;
        reset_dut();
        step(6);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hA00000AA || instr_pc !== 32'h0) begin
            errors++; $display("FAIL bp_hold_head got v=%b %h@%h want v=1 a00000aa@00000000", instr_valid, instr, instr_pc);
        end
        checks++; if (imem_addr !== 32'h08) begin errors++; $display("FAIL bp_addr_stuck got %h want 00000008", imem_addr); end
        instr_ready = 1'b1;
        for (int i = 1; i < 10; i++) begin
            step(1);
            checks++; if (instr_valid !== 1'b1 || instr !== rom[i] || instr_pc !== 32'(i * 4)) begin
                errors++; $display("FAIL bp_resume%0d got v=%b %h@%h want v=1 %h@%h", i, instr_valid, instr, instr_pc, rom[i], 32'(i * 4));
            end
            $display("backpressure resume %0d: instr=%h pc=%h", i, instr, instr_pc);
        end
        step(1);
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL bp_halt got h=%b v=%b want h=1 v=0", halted, instr_valid); end
    endtask

    task automatic test_redirect_full;
        instr_ready = 1'b0;
        reset_dut();
        step(3);
        checks++; if (instr_valid !== 1'b1 || imem_addr !== 32'h08) begin errors++; $display("FAIL redir_prefull got v=%b addr=%h want v=1 00000008", instr_valid, imem_addr); end
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h17;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h14) begin errors++; $display("FAIL redir_flush got v=%b addr=%h want v=0 00000014", instr_valid, imem_addr); end
        step(1);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h50000055 || instr_pc !== 32'h14) begin
            errors++; $display("FAIL redir_target got v=%b %h@%h want v=1 50000055@00000014", instr_valid, instr, instr_pc);
        end
        $display("redirect from full: instr=%h pc=%h", instr, instr_pc);
    endtask

    task automatic test_halt_redirect;
        instr_ready = 1'b1;
        reset_dut();
        step(12);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hr_halted got %b want 1", halted); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL hr_leave got h=%b v=%b want h=0 v=0", halted, instr_valid); end
        step(1);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hA00000AA || instr_pc !== 32'h0) begin
            errors++; $display("FAIL hr_restart0 got v=%b %h@%h want v=1 a00000aa@00000000", instr_valid, instr, instr_pc);
        end
        step(1);
        checks++; if (instr !== 32'h10000011 || instr_pc !== 32'h4) begin errors++; $display("FAIL hr_restart1 got %h@%h want 10000011@00000004", instr, instr_pc); end
        $display("halt redirect: instr=%h pc=%h", instr, instr_pc);
    endtask

    task automatic test_reset_mid;
        instr_ready = 1'b1;
        reset_dut();
        step(4);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h20000022) begin errors++; $display("FAIL rm_pre got v=%b %h want v=1 20000022", instr_valid, instr); end
        rst = 1'b1;
        step(1);
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0 || halted !== 1'b0) begin
            errors++; $display("FAIL rm_reset got v=%b addr=%h instr=%h h=%b want v=0 0 0 h=0", instr_valid, imem_addr, instr, halted);
        end
        rst = 1'b0;
        step(1);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_boot got v=%b want 0", instr_valid); end
        step(1);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hA00000AA) begin errors++; $display("FAIL rm_first got v=%b %h want v=1 a00000aa", instr_valid, instr); end
        $display("reset mid-stream: instr=%h pc=%h", instr, instr_pc);
    endtask

    task automatic test_redirect_boot;
        instr_ready = 1'b1;
        reset_dut();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0E;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0C) begin errors++; $display("FAIL rb_boot got v=%b addr=%h want v=0 0000000c", instr_valid, imem_addr); end
        step(1);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h30000033 || instr_pc !== 32'h0C) begin
            errors++; $display("FAIL rb_target got v=%b %h@%h want v=1 30000033@0000000c", instr_valid, instr, instr_pc);
        end
        $display("redirect in boot: instr=%h pc=%h", instr, instr_pc);
    endtask

`ifdef IFETCH_PERF_CNT_EN
    task automatic test_perf;
        instr_ready = 1'b1;
        reset_dut();
        step(13);
        checks++; if (perf_fetched !== 32'd10 || perf_stall !== 32'd0) begin
            errors++; $display("FAIL perf_run got f=%0d s=%0d want f=10 s=0", perf_fetched, perf_stall);
        end
        instr_ready = 1'b0;
        reset_dut();
        step(3);
        checks++; if (perf_stall !== 32'd0) begin errors++; $display("FAIL perf_full got s=%0d want 0", perf_stall); end
        step(4);
        checks++; if (perf_stall !== 32'd4) begin errors++; $display("FAIL perf_stall got s=%0d want 4", perf_stall); end
        $display("perf: fetched=%0d stall=%0d", perf_fetched, perf_stall);
    endtask
`endif

    initial begin
        rom[0] = 32'hA00000AA;
        for (int i = 1; i < 10; i++) begin
            rom[i] = {4'(i), 20'h0, 4'(i), 4'(i)};
        end
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        step(2);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_halt_redirect();
        test_reset_mid();
        test_redirect_boot();
`ifdef IFETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
